// File: rtl/mipsmulti_pkg.sv
// Shared types and encodings for the handshaking multicycle MIPS controller:
// FSM states, opcode/funct fields, ALU control codes and the decoded control bundle.
package mipsmulti_pkg;

  typedef enum logic [4:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    RTYPEEX,
    RTYPEWB,
    BEQEX,
    BNEEX,
    ADDIEX,
    ANDIEX,
    ORIEX,
    IMMWB,
    JEX,
    JALEX,
    FAULT
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    AOP_ADD,
    AOP_SUB,
    AOP_AND,
    AOP_OR,
    AOP_FUNCT
  } aluop_t;

  // Raw per-state controls before pcen is formed and before reset gating.
  typedef struct packed {
    logic       memreq;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       immzext;
    logic       pcwrite;
    logic       branch;
    logic       branchne;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
  } ctrl_t;

  function automatic logic isWaitState(state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mipsmulti_aludec_ext.sv
// ALU decoder: turns the FSM's aluop plus the instruction funct field into
// alucontrol, and flags whether the funct is one the datapath supports.
module mipsmulti_aludec_ext
  import mipsmulti_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_legal
);

  logic [2:0] functAlu;

  always_comb begin
    funct_legal = 1'b1;
    functAlu    = ALU_ADD;
    case (funct)
      F_ADD:   functAlu = ALU_ADD;
      F_SUB:   functAlu = ALU_SUB;
      F_AND:   functAlu = ALU_AND;
      F_OR:    functAlu = ALU_OR;
      F_SLT:   functAlu = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      AOP_ADD:   alucontrol = ALU_ADD;
      AOP_SUB:   alucontrol = ALU_SUB;
      AOP_AND:   alucontrol = ALU_AND;
      AOP_OR:    alucontrol = ALU_OR;
      AOP_FUNCT: alucontrol = functAlu;
      default:   alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mipsmulti_ctrl_hs.sv
// Multicycle MIPS controller with a variable-latency memory handshake, a bounded
// wait timeout and a sticky FAULT state for illegal instructions and timeouts.
module mipsmulti_ctrl_hs
  import mipsmulti_pkg::*;
#(
  parameter int EXT_OPS    = 1,
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memreq,
  output logic       memwrite,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       immzext,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       fault
);

  localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

  state_t           state;
  state_t           nextState;
  logic [CNT_W-1:0] waitCnt;
  ctrl_t            c;
  aluop_t           aluop;
  logic             aluUsed;
  logic [2:0]       decAlu;
  logic             functLegal;
  logic             timeout;
  logic             extOn;

  assign extOn   = (EXT_OPS != 0);
  assign timeout = isWaitState(state) && !mem_ready
                   && (waitCnt == CNT_W'(WAIT_LIMIT));

  mipsmulti_aludec_ext u_aludec (
    .aluop       (aluop),
    .funct       (funct),
    .alucontrol  (decAlu),
    .funct_legal (functLegal)
  );

  // The wait counter restarts on every state change, so each memory wait is
  // measured from its own first cycle; at the limit the FSM leaves, so it never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      waitCnt <= '0;
    end else begin
      state <= nextState;
      if (nextState != state)
        waitCnt <= '0;
      else if (isWaitState(state) && !mem_ready)
        waitCnt <= waitCnt + CNT_W'(1);
    end
  end

  always_comb begin
    nextState = state;
    c         = '0;
    aluop     = AOP_ADD;
    aluUsed   = 1'b0;
    case (state)
      FETCH: begin
        c.memreq  = 1'b1;
        c.alusrcb = 2'b01;
        aluUsed   = 1'b1;
        c.irwrite = mem_ready;
        c.pcwrite = mem_ready;
        if (mem_ready)    nextState = DECODE;
        else if (timeout) nextState = FAULT;
      end
      DECODE: begin
        c.alusrcb = 2'b11;
        aluUsed   = 1'b1;
        case (op)
          OP_LW, OP_SW: nextState = MEMADR;
          OP_RTYPE:     nextState = functLegal ? RTYPEEX : FAULT;
          OP_BEQ:       nextState = BEQEX;
          OP_ADDI:      nextState = ADDIEX;
          OP_J:         nextState = JEX;
          OP_BNE:       nextState = extOn ? BNEEX  : FAULT;
          OP_ANDI:      nextState = extOn ? ANDIEX : FAULT;
          OP_ORI:       nextState = extOn ? ORIEX  : FAULT;
          OP_JAL:       nextState = extOn ? JALEX  : FAULT;
          default:      nextState = FAULT;
        endcase
      end
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        aluUsed   = 1'b1;
        nextState = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        c.memreq = 1'b1;
        c.iord   = 1'b1;
        if (mem_ready)    nextState = MEMWB;
        else if (timeout) nextState = FAULT;
      end
      MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 2'b01;
        nextState  = FETCH;
      end
      MEMWR: begin
        c.memreq   = 1'b1;
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
        if (mem_ready)    nextState = FETCH;
        else if (timeout) nextState = FAULT;
      end
      RTYPEEX: begin
        c.alusrca = 1'b1;
        aluop     = AOP_FUNCT;
        aluUsed   = 1'b1;
        nextState = RTYPEWB;
      end
      RTYPEWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 2'b01;
        nextState  = FETCH;
      end
      BEQEX, BNEEX: begin
        c.alusrca  = 1'b1;
        c.pcsrc    = 2'b01;
        aluop      = AOP_SUB;
        aluUsed    = 1'b1;
        c.branch   = (state == BEQEX);
        c.branchne = (state == BNEEX);
        nextState  = FETCH;
      end
      ADDIEX, ANDIEX, ORIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        aluUsed   = 1'b1;
        c.immzext = (state != ADDIEX);
        if (state == ANDIEX)     aluop = AOP_AND;
        else if (state == ORIEX) aluop = AOP_OR;
        nextState = IMMWB;
      end
      IMMWB: begin
        c.regwrite = 1'b1;
        nextState  = FETCH;
      end
      JEX: begin
        c.pcwrite = 1'b1;
        c.pcsrc   = 2'b10;
        nextState = FETCH;
      end
      // PC already holds PC+4 here, so the link value and the jump land on one edge.
      JALEX: begin
        c.pcwrite  = 1'b1;
        c.pcsrc    = 2'b10;
        c.regwrite = 1'b1;
        c.regdst   = 2'b10;
        c.memtoreg = 2'b10;
        nextState  = FETCH;
      end
      FAULT:   nextState = FAULT;
      default: nextState = FAULT;
    endcase
  end

  // Reset gates every output so an access in flight is withdrawn at once.
  assign memreq     = ~reset & c.memreq;
  assign memwrite   = ~reset & c.memwrite;
  assign irwrite    = ~reset & c.irwrite;
  assign regwrite   = ~reset & c.regwrite;
  assign alusrca    = ~reset & c.alusrca;
  assign iord       = ~reset & c.iord;
  assign immzext    = ~reset & c.immzext;
  assign pcen       = ~reset & (c.pcwrite | (c.branch & zero) | (c.branchne & ~zero));
  assign regdst     = reset ? 2'b00 : c.regdst;
  assign memtoreg   = reset ? 2'b00 : c.memtoreg;
  assign alusrcb    = reset ? 2'b00 : c.alusrcb;
  assign pcsrc      = reset ? 2'b00 : c.pcsrc;
  assign alucontrol = (reset || !aluUsed) ? 3'b000 : decAlu;
  assign fault      = ~reset & (state == FAULT);

endmodule

// File: tb/tb_mipsmulti_ctrl_hs.sv
// Scoreboard bench: two controller instances (full ISA / long timeout, base ISA / short
// timeout) run instruction streams built from a per-instruction step model.
module tb_mipsmulti_ctrl_hs;

  typedef struct packed {
    logic       memreq, memwrite, pcen, irwrite, regwrite, alusrca, iord, immzext;
    logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       fault;
  } outs_t;

  typedef struct {
    bit       rst;
    bit [5:0] op;
    bit [5:0] funct;
    bit       zero;
    bit       mr;
    outs_t    exp;
    string    step;
  } cyc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstA, zeroA, mrA, rstB, zeroB, mrB;
  logic [5:0] opA, functA, opB, functB;
  logic       memreqA, memwriteA, pcenA, irwriteA, regwriteA, alusrcaA, iordA, immzextA, faultA;
  logic       memreqB, memwriteB, pcenB, irwriteB, regwriteB, alusrcaB, iordB, immzextB, faultB;
  logic [1:0] regdstA, memtoregA, alusrcbA, pcsrcA, regdstB, memtoregB, alusrcbB, pcsrcB;
  logic [2:0] alucontrolA, alucontrolB;
  outs_t      actA, actB;

  assign actA = {memreqA, memwriteA, pcenA, irwriteA, regwriteA, alusrcaA, iordA, immzextA,
                 regdstA, memtoregA, alusrcbA, pcsrcA, alucontrolA, faultA};
  assign actB = {memreqB, memwriteB, pcenB, irwriteB, regwriteB, alusrcaB, iordB, immzextB,
                 regdstB, memtoregB, alusrcbB, pcsrcB, alucontrolB, faultB};

  mipsmulti_ctrl_hs #(.EXT_OPS(1), .WAIT_LIMIT(15)) dutA (
    .clk(clk), .reset(rstA), .op(opA), .funct(functA), .zero(zeroA), .mem_ready(mrA),
    .memreq(memreqA), .memwrite(memwriteA), .pcen(pcenA), .irwrite(irwriteA),
    .regwrite(regwriteA), .alusrca(alusrcaA), .iord(iordA), .immzext(immzextA),
    .regdst(regdstA), .memtoreg(memtoregA), .alusrcb(alusrcbA), .pcsrc(pcsrcA),
    .alucontrol(alucontrolA), .fault(faultA)
  );

  mipsmulti_ctrl_hs #(.EXT_OPS(0), .WAIT_LIMIT(4)) dutB (
    .clk(clk), .reset(rstB), .op(opB), .funct(functB), .zero(zeroB), .mem_ready(mrB),
    .memreq(memreqB), .memwrite(memwriteB), .pcen(pcenB), .irwrite(irwriteB),
    .regwrite(regwriteB), .alusrca(alusrcaB), .iord(iordB), .immzext(immzextB),
    .regdst(regdstB), .memtoreg(memtoregB), .alusrcb(alusrcbB), .pcsrc(pcsrcB),
    .alucontrol(alucontrolB), .fault(faultB)
  );

  cyc_t stimA[$], stimB[$], expA[$], expB[$];
  int   total = 0;
  int   bad   = 0;

  function automatic int limitOf(int k);
    return (k == 0) ? 15 : 4;
  endfunction

  function automatic bit rbit();
    return 1'($urandom);
  endfunction

  function automatic bit functOk(bit [5:0] f);
    return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 || f == 6'b100101 || f == 6'b101010;
  endfunction

  function automatic bit [2:0] functAlu(bit [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic string opClass(bit [5:0] op, bit ext);
    case (op)
      6'b100011: return "LW";
      6'b101011: return "SW";
      6'b000000: return "R";
      6'b000100: return "BEQ";
      6'b001000: return "ADDI";
      6'b000010: return "J";
      6'b000101: return ext ? "BNE"  : "BAD";
      6'b001100: return ext ? "ANDI" : "BAD";
      6'b001101: return ext ? "ORI"  : "BAD";
      6'b000011: return ext ? "JAL"  : "BAD";
      default:   return "BAD";
    endcase
  endfunction

  // What the datapath must see during one step of an instruction.
  function automatic outs_t stepOuts(string step, bit mr, bit z, bit [5:0] funct);
    outs_t o = '0;
    case (step)
      "FETCH":   begin o.memreq = 1; o.alusrcb = 2'b01; o.alucontrol = 3'b010; o.irwrite = mr; o.pcen = mr; end
      "DECODE":  begin o.alusrcb = 2'b11; o.alucontrol = 3'b010; end
      "MEMADR":  begin o.alusrca = 1; o.alusrcb = 2'b10; o.alucontrol = 3'b010; end
      "MEMRD":   begin o.memreq = 1; o.iord = 1; end
      "MEMWB":   begin o.regwrite = 1; o.memtoreg = 2'b01; end
      "MEMWR":   begin o.memreq = 1; o.memwrite = 1; o.iord = 1; end
      "RTYPEEX": begin o.alusrca = 1; o.alucontrol = functAlu(funct); end
      "RTYPEWB": begin o.regwrite = 1; o.regdst = 2'b01; end
      "BEQEX":   begin o.alusrca = 1; o.alucontrol = 3'b110; o.pcsrc = 2'b01; o.pcen = z; end
      "BNEEX":   begin o.alusrca = 1; o.alucontrol = 3'b110; o.pcsrc = 2'b01; o.pcen = !z; end
      "ADDIEX":  begin o.alusrca = 1; o.alusrcb = 2'b10; o.alucontrol = 3'b010; end
      "ANDIEX":  begin o.alusrca = 1; o.alusrcb = 2'b10; o.immzext = 1; o.alucontrol = 3'b000; end
      "ORIEX":   begin o.alusrca = 1; o.alusrcb = 2'b10; o.immzext = 1; o.alucontrol = 3'b001; end
      "IMMWB":   o.regwrite = 1;
      "JEX":     begin o.pcen = 1; o.pcsrc = 2'b10; end
      "JALEX":   begin o.pcen = 1; o.pcsrc = 2'b10; o.regwrite = 1; o.regdst = 2'b10; o.memtoreg = 2'b10; end
      "FAULT":   o.fault = 1;
      default:   o = '0;
    endcase
    return o;
  endfunction

  function automatic void pushCyc(int k, bit rst, bit [5:0] op, bit [5:0] funct, bit z, bit mr, string step);
    cyc_t e;
    e.rst = rst; e.op = op; e.funct = funct; e.zero = z; e.mr = mr; e.step = step;
    e.exp = rst ? '0 : stepOuts(step, mr, z, funct);
    if (k == 0) stimA.push_back(e);
    else        stimB.push_back(e);
  endfunction

  function automatic void resetCycle(int k);
    pushCyc(k, 1, 6'($urandom), 6'($urandom), rbit(), rbit(), "RESET");
  endfunction

  function automatic void faultTail(int k);
    for (int i = 0; i < 2; i++) pushCyc(k, 0, 6'($urandom), 6'($urandom), rbit(), rbit(), "FAULT");
    resetCycle(k);
  endfunction

  // A memory step holds for 'waits' not-ready cycles; beyond the limit it faults.
  function automatic bit waitStep(int k, string step, int waits, bit [5:0] op, bit [5:0] funct);
    int lim = limitOf(k);
    for (int i = 0; i <= lim && i < waits; i++) pushCyc(k, 0, op, funct, rbit(), 0, step);
    if (waits > lim) begin
      faultTail(k);
      return 0;
    end
    pushCyc(k, 0, op, funct, rbit(), 1, step);
    return 1;
  endfunction

  function automatic void runInstr(int k, bit [5:0] op, bit [5:0] funct, bit zEx, int fw, int mw);
    string cls = opClass(op, k == 0);
    if (!waitStep(k, "FETCH", fw, op, funct)) return;
    pushCyc(k, 0, op, funct, rbit(), rbit(), "DECODE");
    case (cls)
      "LW": begin
        pushCyc(k, 0, op, funct, rbit(), rbit(), "MEMADR");
        if (!waitStep(k, "MEMRD", mw, op, funct)) return;
        pushCyc(k, 0, op, funct, rbit(), rbit(), "MEMWB");
      end
      "SW": begin
        pushCyc(k, 0, op, funct, rbit(), rbit(), "MEMADR");
        void'(waitStep(k, "MEMWR", mw, op, funct));
      end
      "R": begin
        if (!functOk(funct)) begin faultTail(k); return; end
        pushCyc(k, 0, op, funct, rbit(), rbit(), "RTYPEEX");
        pushCyc(k, 0, op, funct, rbit(), rbit(), "RTYPEWB");
      end
      "BEQ":  pushCyc(k, 0, op, funct, zEx, rbit(), "BEQEX");
      "BNE":  pushCyc(k, 0, op, funct, zEx, rbit(), "BNEEX");
      "ADDI", "ANDI", "ORI": begin
        pushCyc(k, 0, op, funct, rbit(), rbit(), {cls, "EX"});
        pushCyc(k, 0, op, funct, rbit(), rbit(), "IMMWB");
      end
      "J":    pushCyc(k, 0, op, funct, rbit(), rbit(), "JEX");
      "JAL":  pushCyc(k, 0, op, funct, rbit(), rbit(), "JALEX");
      default: faultTail(k);
    endcase
  endfunction

  function automatic void swAbort(int k);
    pushCyc(k, 0, 6'b101011, 6'h00, rbit(), 1, "FETCH");
    pushCyc(k, 0, 6'b101011, 6'h00, rbit(), rbit(), "DECODE");
    pushCyc(k, 0, 6'b101011, 6'h00, rbit(), rbit(), "MEMADR");
    pushCyc(k, 0, 6'b101011, 6'h00, rbit(), 0, "MEMWR");
    resetCycle(k);
  endfunction

  function automatic void randomInstr(int k);
    bit [5:0] opTab [10];
    bit [5:0] fTab [5];
    bit [5:0] op, funct;
    int       lim = limitOf(k);
    int       fw, mw;
    opTab = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
              6'b001000, 6'b001100, 6'b001101, 6'b000010, 6'b000011};
    fTab  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    op    = ($urandom_range(0, 11) < 10) ? opTab[$urandom_range(0, 9)] : 6'($urandom);
    funct = ($urandom_range(0, 4) != 0) ? fTab[$urandom_range(0, 4)] : 6'($urandom);
    fw    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, lim + 2)) : int'($urandom_range(0, 2));
    mw    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, lim + 2)) : int'($urandom_range(0, 2));
    runInstr(k, op, funct, rbit(), fw, mw);
  endfunction

  task automatic applyStimulus(int k, cyc_t e);
    if (k == 0) begin
      rstA = e.rst; opA = e.op; functA = e.funct; zeroA = e.zero; mrA = e.mr;
    end else begin
      rstB = e.rst; opB = e.op; functB = e.funct; zeroB = e.zero; mrB = e.mr;
    end
  endtask

  task automatic checkOutput(int k, cyc_t e, outs_t act);
    total++;
    if (act !== e.exp) begin
      bad++;
      $display("[TB] FAIL dut%0d step=%s op=%b funct=%b mr=%0d zero=%0d got=%h want=%h",
               k, e.step, e.op, e.funct, e.mr, e.zero, act, e.exp);
    end
  endtask

  task automatic driveA();
    cyc_t e;
    while (stimA.size() > 0) begin
      @(posedge clk); #1;
      e = stimA.pop_front();
      applyStimulus(0, e);
      expA.push_back(e);
    end
  endtask

  task automatic driveB();
    cyc_t e;
    while (stimB.size() > 0) begin
      @(posedge clk); #1;
      e = stimB.pop_front();
      applyStimulus(1, e);
      expB.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    cyc_t e;
    if (expA.size() > 0) begin
      e = expA.pop_front();
      checkOutput(0, e, actA);
    end
    if (expB.size() > 0) begin
      e = expB.pop_front();
      checkOutput(1, e, actB);
    end
  end

  initial begin
    rstA = 1; opA = '0; functA = '0; zeroA = 0; mrA = 0;
    rstB = 1; opB = '0; functB = '0; zeroB = 0; mrB = 0;
    resetCycle(0);
    resetCycle(1);

    // Full ISA, WAIT_LIMIT 15
    runInstr(0, 6'b100011, 6'h00, 0, 0, 0);
    runInstr(0, 6'b101011, 6'h00, 0, 0, 3);
    runInstr(0, 6'b000011, 6'h00, 0, 0, 0);
    runInstr(0, 6'b001101, 6'h00, 0, 0, 0);
    runInstr(0, 6'b001100, 6'h00, 0, 1, 0);
    runInstr(0, 6'b000101, 6'h00, 0, 0, 0);
    runInstr(0, 6'b000101, 6'h00, 1, 0, 0);
    runInstr(0, 6'b000100, 6'h00, 1, 0, 0);
    runInstr(0, 6'b000100, 6'h00, 0, 0, 0);
    runInstr(0, 6'b000000, 6'b101010, 0, 0, 0);
    runInstr(0, 6'b000000, 6'b000111, 0, 0, 0);
    runInstr(0, 6'b100011, 6'h00, 0, 15, 15);
    runInstr(0, 6'b100011, 6'h00, 0, 16, 0);
    runInstr(0, 6'b101011, 6'h00, 0, 0, 16);
    swAbort(0);
    runInstr(0, 6'b000010, 6'h00, 0, 0, 0);

    // Base ISA, WAIT_LIMIT 4
    runInstr(1, 6'b100011, 6'h00, 0, 5, 0);
    runInstr(1, 6'b000101, 6'h00, 0, 0, 0);
    runInstr(1, 6'b001101, 6'h00, 0, 0, 0);
    runInstr(1, 6'b000011, 6'h00, 0, 0, 0);
    runInstr(1, 6'b100011, 6'h00, 0, 4, 4);
    runInstr(1, 6'b101011, 6'h00, 0, 0, 5);
    runInstr(1, 6'b001000, 6'h00, 0, 0, 0);
    runInstr(1, 6'b000010, 6'h00, 0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      randomInstr(0);
      randomInstr(1);
    end

    fork
      driveA();
      driveB();
    join
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mipsmulti_ctrl_hs.md
Name: mipsmulti_ctrl_hs

Overview:
- Next-generation multicycle MIPS controller: Moore FSM plus ALU decoder, driving the existing multicycle datapath.
- Adds a variable-latency memory handshake (memreq/mem_ready) with a bounded wait timeout.
- Optionally adds andi, ori, bne and jal.
- Unknown opcodes, unknown functs and memory timeouts go to a sticky FAULT state. Control outputs are never driven to X.

Parameters:
- EXT_OPS, 1: 1 enables andi/ori/bne/jal; 0 treats those opcodes as illegal.
- WAIT_LIMIT, 15: maximum cycles a memory state waits for mem_ready before FAULT; legal range 1..255.
- CNT_W, $clog2(WAIT_LIMIT+1): wait-counter width; derived, never overridden.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; forces FETCH, clears counter and fault.
- op  in  6  instr[31:26].
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- memreq  out  1  memory access request.
- memwrite  out  1  write strobe; only ever high together with memreq.
- pcen  out  1  PC register enable.
- irwrite  out  1  instruction register enable.
- regwrite  out  1  register file write enable.
- alusrca  out  1  0=PC, 1=A.
- iord  out  1  0=PC address, 1=ALUOut address.
- immzext  out  1  1=zero-extend imm (andi/ori), 0=sign-extend.
- regdst  out  2  00=rt, 01=rd, 10=$31.
- memtoreg  out  2  00=ALUOut, 01=Data, 10=PC.
- alusrcb  out  2  00=B, 01=4, 10=imm, 11=imm<<2.
- pcsrc  out  2  00=ALUResult, 01=ALUOut, 10=jump target.
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- fault  out  1  sticky; high in FAULT.

Behaviour:
- Single clock clk. reset is asynchronous and active-high: state goes to FETCH, wait counter to 0, fault to 0. All outputs are forced to 0 while reset is high.
- Outputs are a combinational function of the state, except where gated by mem_ready or zero as listed below. Every output not listed for a state is 0.
- pcen = pcwrite | (branch & zero) | (branchne & ~zero).
- FETCH:
  - Outputs: memreq=1, iord=0, alusrca=0, alusrcb=01, add, pcsrc=00.
  - irwrite and pcwrite are each = mem_ready.
  - Next state: DECODE on mem_ready, otherwise stay.
- DECODE: alusrcb=11, add. Next state by op:
  - lw or sw -> MEMADR.
  - R-type with legal funct -> RTYPEEX; illegal funct -> FAULT.
  - beq -> BEQEX; addi -> ADDIEX; j -> JEX.
  - When EXT_OPS=1: bne -> BNEEX, andi -> ANDIEX, ori -> ORIEX, jal -> JALEX.
  - Any other op -> FAULT.
- MEMADR: alusrca=1, alusrcb=10, add. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: memreq=1, iord=1. Next state MEMWB on mem_ready, otherwise stay.
- MEMWB: regwrite=1, regdst=00, memtoreg=01. Next state FETCH.
- MEMWR: memreq=1, memwrite=1, iord=1. Next state FETCH on mem_ready, otherwise stay. memwrite is held for the entire wait.
- RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct (add 100000, sub 100010, and 100100, or 100101, slt 101010). Next state RTYPEWB.
- RTYPEWB: regwrite=1, regdst=01, memtoreg=00. Next state FETCH.
- BEQEX: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1. Next state FETCH.
- BNEEX: same as BEQEX but branchne=1 instead of branch. Next state FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add. Next state IMMWB.
- ANDIEX: as ADDIEX but immzext=1 and alucontrol=and. Next state IMMWB.
- ORIEX: as ADDIEX but immzext=1 and alucontrol=or. Next state IMMWB.
- IMMWB: regwrite=1, regdst=00, memtoreg=00. Next state FETCH.
- JEX: pcwrite=1, pcsrc=10. Next state FETCH.
- JALEX: pcwrite=1, pcsrc=10, regwrite=1, regdst=10, memtoreg=10. Writes the old PC (already PC+4) to $31 on the same edge as the PC update. Next state FETCH.
- Wait counter:
  - Clears on every state transition.
  - Increments each cycle spent in FETCH, MEMRD or MEMWR while mem_ready=0.
  - If the count equals WAIT_LIMIT and mem_ready=0 -> FAULT.
  - mem_ready on the limit cycle still completes normally.
- FAULT: all outputs 0 except fault=1. Only reset exits this state.
- Latencies with mem_ready always 1: lw 5 cycles; sw 4; R-type, addi, andi, ori 4; beq, bne, j, jal 3.
- Reset mid-access: memreq drops immediately (async). No partial write is committed by the controller.

Decomposition:
- Package mipsmulti_pkg holds:
  - the state enum (FETCH..FAULT, 5-bit),
  - opcode constants (LW, SW, RTYPE, BEQ, BNE, ADDI, ANDI, ORI, J, JAL),
  - funct constants,
  - alucontrol constants,
  - the aluop enum (ADD, SUB, AND, OR, FUNCT).
- One combinational sub-module, mipsmulti_aludec_ext: maps aluop and funct to alucontrol, and outputs a funct_legal flag used by DECODE.

Test Plan:
- Reset released, mem_ready=1, fetch lw (op 100011) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; regwrite=1 with memtoreg=01 in cycle 5 only.
- sw with mem_ready low 3 cycles in MEMWR, WAIT_LIMIT=15 -> memreq=1 and memwrite=1 held for 4 cycles; FETCH entered on the cycle after mem_ready; fault=0.
- mem_ready stuck 0 in FETCH, WAIT_LIMIT=4 -> FAULT after 5 cycles in FETCH, fault=1, all strobes 0; reset pulse -> FETCH, fault=0.
- bne (op 000101) with zero=0 -> pcen=1 in BNEEX; with zero=1 -> pcen=0. With EXT_OPS=0, same op -> FAULT after DECODE.
- jal (op 000011) -> JALEX asserts pcwrite=1, regwrite=1, regdst=10, memtoreg=10, pcsrc=10 for exactly 1 cycle.
- R-type with funct 000111 -> FAULT from DECODE. ori (op 001101) -> ORIEX with immzext=1 and alucontrol=001, then IMMWB.
